flot_mul_seq: RTL and testbench
===============================

Name: flot_mul_seq

Overview:
Multi-cycle IEEE-754-style floating-point multiplier, result = OP1 * OP2. It computes the mantissa product with a radix-2 shift-add datapath instead of a full-width array multiplier. It is the area-lean inverse-operation companion to the divide path and is used where throughput of one result per ~27 cycles is acceptable. A start/busy/done handshake lets a sequencer issue operands and collect results.

Parameters:
WIDTH, 32, total operand/result bits (sign + exponent + mantissa)
WIDTH_exp, 8, exponent field width; bias = 2^(WIDTH_exp-1)-1 (localparam, 127 at default)
WIDTH_mat, 23, stored mantissa width; hidden bit added internally (WIDTH_mat+1 = 24 product steps)

Ports:
CLK  input  1  clock; all logic on rising edge
RST  input  1  synchronous reset, active-high
CE  input  1  clock enable; low freezes all state and outputs
start  input  1  request; sampled only when idle and CE=1
OP1  input  WIDTH  multiplicand, sampled with accepted start
OP2  input  WIDTH  multiplier, sampled with accepted start
exce_in  input  1  upstream exception, sampled with accepted start
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse: result/exce_out valid
result  output  WIDTH_mat+WIDTH_exp+1  product; held until the next done
exce_out  output  1  exception flag for result; held with result

Behaviour:
- Reset (RST=1 at edge): state=IDLE, busy=0, done=0, result=0, exce_out=0, step counter=0. Reset mid-operation aborts; no done is ever produced for the aborted operation.
- CE=0: no state, counter, or output changes, including done; a done pulse lasts one CE-high edge. Latencies below count CE-high edges only.
- States: IDLE -> UNPACK -> MUL -> NORM -> IDLE.
- IDLE: on start=1, register OP1, OP2, and exce_in (edge E0), then go to UNPACK with busy=1. start while busy is ignored; no queueing.
- UNPACK (E1):
  - sign = s1^s2.
  - Mantissas get hidden bit 1 (width 24).
  - Exponent sum = e1+e2-bias, held in WIDTH_exp+2 signed bits.
  - Classify specials. Clear the 48-bit accumulator and set cnt=0.
- MUL (E2..E25):
  - Each edge: if multiplier LSB=1, add the shifted multiplicand to the accumulator; shift the multiplier right; increment cnt.
  - Leave MUL when cnt reaches WIDTH_mat+1 (24 steps).
- NORM (E26):
  - Product is in [1,4). If bit 47 is set, mantissa = acc[46:24] and exponent+1; otherwise mantissa = acc[45:23].
  - Rounding is truncation (toward zero).
  - Register result and exce_out, set done=1, set busy=0, return to IDLE.
- Latency: done is high in the cycle after E26, i.e. 26 CE-high edges after the start-sampling edge.
- A start present during the done cycle is accepted (state is IDLE). Back-to-back issue interval is 27 edges.
- Special cases, resolved in UNPACK (the datapath still runs, so latency is fixed):
  - Either exponent field = 0 (zero/denormal, flushed): result = {sign, 0...}, exce_out = exce_in.
  - Either exponent field = all-ones: result = {sign, all-ones exp, 0 mantissa}, exce_out=1. This takes precedence over zero.
  - Final biased exponent >= 2^WIDTH_exp-1 (overflow): result = {sign, all-ones exp, 0 mantissa}, exce_out=1.
  - Final biased exponent <= 0 (underflow): result = {sign, 0...}, exce_out=1.
  - Otherwise exce_out = exce_in.
- result and exce_out change only on the NORM edge or on reset.

Test Plan:
- Issue OP1=0x40000000 (2.0), OP2=0x40400000 (3.0), CE=1 -> done pulses 26 edges after start with result=0x40C00000 (6.0), exce_out=0; busy high for exactly those 26 cycles.
- Issue 0x3FC00000 * 0x3FC00000 (1.5^2) -> result=0x40100000 (2.25), checking the normalize shift. Issue 0x3F800001 * 0x3F800001 -> result=0x3F800002, checking truncation.
- Issue 0x7F000000 * 0x40000000 -> result=0x7F800000, exce_out=1. Issue 0x00800000 * 0x00800000 -> result=0x00000000, exce_out=1. Issue 0x00000000 * 0xC0400000 -> result=0x80000000, exce_out=0.
- Pull CE low for 5 cycles mid-MUL on 2.0*3.0 -> done arrives 31 cycles after start, result 0x40C00000. Pulse start again at cycle 10 while busy -> ignored, exactly one done.
- Assert RST at cycle 10 of an operation -> next cycle busy=0, done=0, result=0, and no done follows. A new start then completes normally in 26 edges.
- Issue 1.0*1.0 with exce_in=1 -> result=0x3F800000, exce_out=1. Issue a second start in the done cycle -> accepted; its done arrives 26 edges later.

Source files
------------

// File: rtl/flot_mul_seq.sv
// Sequential floating-point multiplier: the mantissa product is built with a
// radix-2 shift-add loop, one partial product per clock-enabled edge.
`timescale 1ns/1ps

module flot_mul_seq #(
   parameter int WIDTH     = 32,
   parameter int WIDTH_exp = 8,
   parameter int WIDTH_mat = 23
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           CE,
   input  logic                           start,
   input  logic [WIDTH-1:0]               OP1,
   input  logic [WIDTH-1:0]               OP2,
   input  logic                           exce_in,
   output logic                           busy,
   output logic                           done,
   output logic [WIDTH_mat+WIDTH_exp:0]   result,
   output logic                           exce_out
);

   localparam int MW = WIDTH_mat + 1;
   localparam int PW = 2 * MW;
   localparam int EW = WIDTH_exp + 2;
   localparam int CW = $clog2(MW + 1);
   localparam logic signed [EW-1:0] BIAS    = EW'((1 << (WIDTH_exp - 1)) - 1);
   localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << WIDTH_exp) - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_UNPACK = 2'd1;
   localparam logic [1:0] S_MUL    = 2'd2;
   localparam logic [1:0] S_NORM   = 2'd3;

   logic [1:0]            r_state;
   logic [WIDTH-1:0]      r_op1;
   logic [WIDTH-1:0]      r_op2;
   logic                  r_exce;
   logic                  r_sign;
   logic                  r_isInf;
   logic                  r_isZero;
   logic [PW-1:0]         r_mcand;
   logic [MW-1:0]         r_mplier;
   logic [PW-1:0]         r_acc;
   logic signed [EW-1:0]  r_exp;
   logic [CW-1:0]         r_cnt;

   logic [WIDTH_exp-1:0]  w_e1;
   logic [WIDTH_exp-1:0]  w_e2;
   logic signed [EW-1:0]  w_expSum;
   logic                  w_norm;
   logic signed [EW-1:0]  w_expFinal;
   logic [WIDTH_mat-1:0]  w_mant;
   logic                  w_ovf;
   logic                  w_unf;

   assign w_e1     = r_op1[WIDTH-2 -: WIDTH_exp];
   assign w_e2     = r_op2[WIDTH-2 -: WIDTH_exp];
   assign w_expSum = $signed({2'b00, w_e1}) + $signed({2'b00, w_e2}) - BIAS;

   // The product of two [1,2) mantissas lies in [1,4); a set top bit means one
   // extra binade, so the window moves up by one and the exponent is bumped.
   assign w_norm     = r_acc[PW-1];
   assign w_expFinal = r_exp + $signed({{(EW-1){1'b0}}, w_norm});
   assign w_mant     = w_norm ? r_acc[PW-2 -: WIDTH_mat] : r_acc[PW-3 -: WIDTH_mat];
   assign w_ovf      = (w_expFinal >= EXP_MAX);
   assign w_unf      = w_expFinal[EW-1] || (w_expFinal == '0);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= S_IDLE;
         r_op1    <= '0;
         r_op2    <= '0;
         r_exce   <= 1'b0;
         r_sign   <= 1'b0;
         r_isInf  <= 1'b0;
         r_isZero <= 1'b0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_exp    <= '0;
         r_cnt    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         exce_out <= 1'b0;
      end else if (CE) begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op1   <= OP1;
                  r_op2   <= OP2;
                  r_exce  <= exce_in;
                  busy    <= 1'b1;
                  r_state <= S_UNPACK;
               end
            end

            // Specials are only classified here; the datapath still runs so
            // the latency never depends on operand values.
            S_UNPACK: begin
               r_sign   <= r_op1[WIDTH-1] ^ r_op2[WIDTH-1];
               r_mcand  <= {{MW{1'b0}}, 1'b1, r_op1[WIDTH_mat-1:0]};
               r_mplier <= {1'b1, r_op2[WIDTH_mat-1:0]};
               r_acc    <= '0;
               r_exp    <= w_expSum;
               r_cnt    <= '0;
               r_isInf  <= (&w_e1) || (&w_e2);
               r_isZero <= (w_e1 == '0) || (w_e2 == '0);
               r_state  <= S_MUL;
            end

            S_MUL: begin
               if (r_mplier[0]) begin
                  r_acc <= r_acc + r_mcand;
               end
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == CW'(MW - 1)) begin
                  r_state <= S_NORM;
               end
            end

            // Infinity/NaN inputs win over zero; overflow and underflow only
            // apply to ordinary operands.
            S_NORM: begin
               if (r_isInf) begin
                  result   <= {r_sign, {WIDTH_exp{1'b1}}, {WIDTH_mat{1'b0}}};
                  exce_out <= 1'b1;
               end else if (r_isZero) begin
                  result   <= {r_sign, {(WIDTH_exp + WIDTH_mat){1'b0}}};
                  exce_out <= r_exce;
               end else if (w_ovf) begin
                  result   <= {r_sign, {WIDTH_exp{1'b1}}, {WIDTH_mat{1'b0}}};
                  exce_out <= 1'b1;
               end else if (w_unf) begin
                  result   <= {r_sign, {(WIDTH_exp + WIDTH_mat){1'b0}}};
                  exce_out <= 1'b1;
               end else begin
                  result   <= {r_sign, w_expFinal[WIDTH_exp-1:0], w_mant};
                  exce_out <= r_exce;
               end
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_flot_mul_seq.sv
// Scoreboard bench for flot_mul_seq: a driver pushes expected results from an
// arithmetic reference model, a monitor pops them whenever done is seen.
`timescale 1ns/1ps

module tb_flot_mul_seq;

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          doneEdge;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic        CE;
   logic        start;
   logic [31:0] OP1;
   logic [31:0] OP2;
   logic        exce_in;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        exce_out;

   exp_t q[$];
   int   nChecks = 0;
   int   nFail   = 0;
   int   ceEdges = 0;
   logic ceNow;
   logic rstNow;

   flot_mul_seq dut (
      .CLK(CLK), .RST(RST), .CE(CE), .start(start),
      .OP1(OP1), .OP2(OP2), .exce_in(exce_in),
      .busy(busy), .done(done), .result(result), .exce_out(exce_out)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      nChecks++;
      if (act !== expv) begin
         nFail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   // Reference: exact integer product of the significands, truncated.
   function automatic exp_t refMul(input logic [31:0] a, input logic [31:0] b, input logic ex);
      exp_t   r;
      logic   s;
      int     e1, e2, e;
      longint p, mant;
      s  = a[31] ^ b[31];
      e1 = int'(a[30:23]);
      e2 = int'(b[30:23]);
      r.doneEdge = 0;
      if (e1 == 255 || e2 == 255) begin
         r.res = {s, 8'hFF, 23'h0};
         r.exc = 1'b1;
         return r;
      end
      if (e1 == 0 || e2 == 0) begin
         r.res = {s, 31'h0};
         r.exc = ex;
         return r;
      end
      p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
      e = e1 + e2 - 127;
      if (p >= (64'sd1 <<< 47)) begin
         mant = p / (64'sd1 <<< 24);
         e    = e + 1;
      end else begin
         mant = p / (64'sd1 <<< 23);
      end
      if (e >= 255) begin
         r.res = {s, 8'hFF, 23'h0};
         r.exc = 1'b1;
      end else if (e <= 0) begin
         r.res = {s, 31'h0};
         r.exc = 1'b1;
      end else begin
         r.res = {s, e[7:0], mant[22:0]};
         r.exc = ex;
      end
      return r;
   endfunction

   // Called at a negedge with the DUT idle and CE high for the coming edge.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic ex);
      exp_t e;
      e          = refMul(a, b, ex);
      e.doneEdge = ceEdges + 27;
      q.push_back(e);
      CE      = 1'b1;
      OP1     = a;
      OP2     = b;
      exce_in = ex;
      start   = 1'b1;
      @(negedge CLK);
      start   = 1'b0;
   endtask

   task automatic waitDone(input bit noise);
      for (int i = 0; i < 400; i++) begin
         @(negedge CLK);
         if (done) begin
            CE = 1'b1;
            return;
         end
         if (noise) CE = ($urandom_range(0, 3) != 0);
      end
      CE = 1'b1;
      nChecks++;
      nFail++;
      $display("[TB] FAIL timeout: got no done, expected done within 400 cycles");
      q.delete();
   endtask

   function automatic logic [31:0] randOp();
      logic [7:0] e;
      int         k;
      k = $urandom_range(0, 15);
      if (k == 0)      e = 8'h00;
      else if (k == 1) e = 8'hFF;
      else if (k < 5)  e = 8'($urandom_range(1, 254));
      else             e = 8'($urandom_range(100, 154));
      return {1'($urandom_range(0, 1)), e, 23'($urandom)};
   endfunction

   // Monitor: samples just after every rising edge.
   always @(posedge CLK) begin
      exp_t e;
      ceNow  = CE;
      rstNow = RST;
      #1;
      if (rstNow) begin
         checkOutput("reset done", {31'h0, done}, 32'h0);
         checkOutput("reset result", result, 32'h0);
         checkOutput("reset exce_out", {31'h0, exce_out}, 32'h0);
      end else if (ceNow) begin
         ceEdges++;
         if (done) begin
            if (q.size() == 0) begin
               nChecks++;
               nFail++;
               $display("[TB] FAIL unexpected done: got done=1 result=%h, expected no done", result);
            end else begin
               e = q.pop_front();
               checkOutput("result", result, e.res);
               checkOutput("exce_out", {31'h0, exce_out}, {31'h0, e.exc});
               checkOutput("latency", 32'(ceEdges), 32'(e.doneEdge));
            end
         end
      end
      checkOutput("busy", {31'h0, busy}, {31'h0, (q.size() > 0)});
   end

   initial begin
      RST = 1'b1; CE = 1'b1; start = 1'b0;
      OP1 = '0; OP2 = '0; exce_in = 1'b0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);

      applyStimulus(32'h40000000, 32'h40400000, 1'b0); waitDone(0);
      applyStimulus(32'h3FC00000, 32'h3FC00000, 1'b0); waitDone(0);
      applyStimulus(32'h3F800001, 32'h3F800001, 1'b0); waitDone(0);
      applyStimulus(32'h7F000000, 32'h40000000, 1'b0); waitDone(0);
      applyStimulus(32'h00800000, 32'h00800000, 1'b0); waitDone(0);
      applyStimulus(32'h00000000, 32'hC0400000, 1'b0); waitDone(0);

      // Clock enable held low for five cycles mid-multiply.
      applyStimulus(32'h40000000, 32'h40400000, 1'b0);
      repeat (9) @(negedge CLK);
      CE = 1'b0;
      repeat (5) @(negedge CLK);
      CE = 1'b1;
      waitDone(0);

      // A second start while busy must be dropped.
      applyStimulus(32'h40000000, 32'h40400000, 1'b0);
      repeat (9) @(negedge CLK);
      OP1 = 32'h3F800000; OP2 = 32'h3F800000; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      waitDone(0);
      repeat (30) @(negedge CLK);

      // Reset mid-operation: the aborted operation never completes.
      applyStimulus(32'h40000000, 32'h40400000, 1'b0);
      repeat (9) @(negedge CLK);
      q.delete();
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      repeat (40) @(negedge CLK);
      applyStimulus(32'h40000000, 32'h40400000, 1'b0); waitDone(0);

      // Exception passthrough, then a start issued in the done cycle.
      applyStimulus(32'h3F800000, 32'h3F800000, 1'b1); waitDone(0);
      applyStimulus(32'hBFC00000, 32'h40800000, 1'b0); waitDone(0);

      for (int i = 0; i < 20; i++) begin
         applyStimulus(randOp(), randOp(), 1'($urandom_range(0, 1)));
         waitDone(1);
      end

      repeat (3) @(negedge CLK);
      if (q.size() != 0) begin
         nChecks++;
         nFail++;
         $display("[TB] FAIL pending: got %0d outstanding results, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no end of test, expected finish before 2ms");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
